bcd_xs3_seq_ctrl: RTL and testbench
===================================

# bcd_xs3_seq_ctrl

Sequencing controller that converts a packed multi-digit 8421 BCD word to Excess-3 code by time-sharing one single-digit converter, feeding it one digit per clock. It accepts words over a valid/ready handshake and returns the packed Excess-3 word over a second handshake, along with per-digit error flags. A global enable stalls the sequence. It sits between a BCD producer (counter or display datapath) and any Excess-3 consumer.

## Interface
- DIGITS, 4, number of BCD digits per word; legal range 2..8.
- clk  input  1  rising-edge clock, the only clock.
- rstn  input  1  reset, synchronous, active-low.
- en  input  1  global enable; 0 stalls conversion and blocks acceptance.
- in_valid  input  1  producer has a word on in_bcd.
- in_ready  output  1  controller can accept a word.
- in_bcd  input  4*DIGITS  packed BCD; digit k at bits [4k+3:4k], digit 0 is least significant.
- out_valid  output  1  result word valid.
- out_ready  input  1  consumer accepts the result.
- out_xs3  output  4*DIGITS  packed Excess-3 result, same digit order as in_bcd.
- out_err_mask  output  DIGITS  bit k is set when input digit k was greater than 9.
- out_err  output  1  OR-reduction of out_err_mask.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready = en.
  - Accept occurs on in_valid & in_ready. On accept:
    - capture in_bcd into the source register;
    - clear out_xs3 and out_err_mask to 0;
    - set the digit counter to 0;
    - go to CONV.
- CONV, when en=1, at each clock edge:
  - the converter sees source digit[cnt];
  - out_xs3 digit[cnt] takes the converter result;
  - out_err_mask[cnt] takes the converter invalid flag;
  - cnt increments.
  - After digit DIGITS-1 is written, go to DONE.
- CONV, when en=0: all registers hold (stall).
- Converter rule:
  - digit ≤ 9: result = digit + 3, 4-bit, no overflow is possible.
  - digit 10..15: result = 4'h0 and invalid = 1.
- DONE:
  - out_valid = 1.
  - out_xs3, out_err_mask and out_err are held stable until out_valid & out_ready.
  - On that handshake, go to IDLE.
  - en does not gate the output handshake.
- in_ready is 0 in CONV and DONE. An input word is never accepted in the same cycle as an output handshake.
- Reset:
  - rstn low at a clock edge forces IDLE, cnt=0, out_valid=0, out_xs3=0, out_err_mask=0, and clears the source register.
  - in_ready is forced to 0 while rstn is low.
  - Reset has priority over en and over both handshakes.
  - Reset during CONV or DONE discards the partial or pending result, with no output handshake.
- out_err is combinational from out_err_mask. in_ready is combinational from state, en and rstn. All other outputs are registered.

## Timing
- Accept at edge E0, with en high throughout: digit k is written at edge E(k+1), and out_valid rises after edge E(DIGITS).
  - Latency is DIGITS cycles from accept to out_valid.
- Each cycle with en=0 during CONV adds exactly one cycle of latency.
- If out_ready is already high when out_valid rises, the handshake completes at the next edge. in_ready is high in the following cycle, so the next accept can occur 1 cycle later.
  - Peak throughput is one word per DIGITS+2 cycles.
- Counter width is $clog2(DIGITS). cnt never exceeds DIGITS-1.
- in_valid while in_ready=0 is ignored. The producer must hold the word until accepted.

## Structure
- Package bcd_xs3_pkg holds:
  - the state enum typedef (IDLE, CONV, DONE);
  - XS3_OFFSET = 4'd3;
  - BCD_MAX = 4'd9;
  - XS3_ERR_NIBBLE = 4'h0.
- Sub-module bcd_xs3_digit is the single shared combinational converter: 4-bit in, 4-bit out, 1-bit invalid flag. It is instantiated exactly once.
- The top level contains the FSM, the counter, the source register and the result registers. Target size is about 150–250 lines.

## Test plan
All scenarios use DIGITS=4.
1. Reset held low for 3 cycles, then released → in_ready=1 the cycle after release; out_valid=0, out_xs3=16'h0000, out_err_mask=4'b0000.
2. Accept in_bcd=16'h1234 with en=1 → out_xs3=16'h4567, out_err_mask=4'b0000, out_err=0. out_valid rises exactly 4 cycles after the accept edge.
3. Accept 16'h0A9F → out_xs3=16'h30C0, out_err_mask=4'b0101, out_err=1.
4. Accept 16'h9870, then drop en for 3 cycles mid-CONV → out_xs3=16'hCBA3 with out_valid 7 cycles after accept; in_valid pulses during the stall are not accepted.
5. With out_ready held low for 5 cycles in DONE → out_valid and the data stay stable and in_ready stays 0. Then raise out_ready → handshake, in_ready=1 the next cycle, and a second word is accepted 1 cycle later.
6. rstn pulsed low for 1 cycle after 2 digits of 16'h5678 have converted → all outputs return to reset values and out_valid never asserts for that word. A new word 16'h0001 then produces 16'h3334.

Source files
------------

// File: rtl/bcd_xs3_pkg.sv
// rtl/bcd_xs3_pkg.sv - shared types and constants for the BCD to Excess-3 sequencer
package bcd_xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_OFFSET     = 4'd3;
  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam logic [3:0] XS3_ERR_NIBBLE = 4'h0;

endpackage

// File: rtl/bcd_xs3_digit.sv
// rtl/bcd_xs3_digit.sv - single-digit 8421 BCD to Excess-3 converter with invalid flag
module bcd_xs3_digit
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_xs3,
  output logic       o_invalid
);

  logic w_invalid;

  assign w_invalid = (i_digit > BCD_MAX);
  assign o_invalid = w_invalid;
  // digits 0..9 add 3 without overflowing 4 bits; codes 10..15 map to a fixed nibble
  assign o_xs3     = w_invalid ? XS3_ERR_NIBBLE : (i_digit + XS3_OFFSET);

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// rtl/bcd_xs3_seq_ctrl.sv - converts a packed BCD word to Excess-3 one digit per clock
module bcd_xs3_seq_ctrl
  import bcd_xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [4*DIGITS-1:0]   r_src;
  logic [4*DIGITS-1:0]   r_xs3;
  logic [DIGITS-1:0]     r_err_mask;
  logic                  r_out_valid;

  logic [3:0]            w_digit;
  logic [3:0]            w_xs3;
  logic                  w_invalid;
  logic                  w_in_ready;

  assign w_digit    = r_src[{r_cnt, 2'b00} +: 4];
  assign w_in_ready = rstn && en && (r_state == IDLE);

  bcd_xs3_digit u_digit (
    .i_digit   (w_digit),
    .o_xs3     (w_xs3),
    .o_invalid (w_invalid)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_src       <= '0;
      r_xs3       <= '0;
      r_err_mask  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && w_in_ready) begin
            r_src      <= in_bcd;
            r_xs3      <= '0;
            r_err_mask <= '0;
            r_cnt      <= '0;
            r_state    <= CONV;
          end
        end
        CONV: begin
          if (en) begin
            r_xs3[{r_cnt, 2'b00} +: 4] <= w_xs3;
            r_err_mask[r_cnt]          <= w_invalid;
            if (r_cnt == LAST) begin
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // output handshake is deliberately independent of en
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_xs3      = r_xs3;
  assign out_err_mask = r_err_mask;
  assign out_err      = |r_err_mask;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// tb/tb_bcd_xs3_seq_ctrl.sv - self-checking bench for bcd_xs3_seq_ctrl against an arithmetic model
module tb_bcd_xs3_seq_ctrl;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           en = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_bcd = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_xs3;
  logic [DIGITS-1:0] out_err_mask;
  logic           out_err;

  int n_checks = 0;
  int n_errors = 0;

  bcd_xs3_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_xs3      (out_xs3),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_xs3(input int word);
    int res = 0;
    int scale = 1;
    for (int k = 0; k < DIGITS; k++) begin
      int d = (word / scale) % 16;
      res += ((d <= 9) ? d + 3 : 0) * scale;
      scale *= 16;
    end
    return res;
  endfunction

  function automatic int ref_mask(input int word);
    int res = 0;
    int scale = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (((word / scale) % 16) > 9) res += (1 << k);
      scale *= 16;
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed one word, optionally stalling en mid-conversion and withholding out_ready in DONE.
  task automatic run_word(input logic [W-1:0] w, input int stall_at, input int stall_len, input int hold);
    int cycles;
    int exp_x;
    int exp_m;
    exp_x = ref_xs3(int'(w));
    exp_m = ref_mask(int'(w));
    en = 1'b1;
    out_ready = 1'b0;
    #1 check("in_ready_idle", in_ready, 1);
    in_bcd = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      en = (cycles >= stall_at && cycles < stall_at + stall_len) ? 1'b0 : 1'b1;
      in_valid = ~en;
      in_bcd = ~w;
      #1 check("in_ready_busy", in_ready, 0);
      tick();
      cycles++;
    end
    en = 1'b1;
    in_valid = 1'b0;
    check("latency", cycles, DIGITS + stall_len);
    check("out_xs3", out_xs3, exp_x);
    check("out_err_mask", out_err_mask, exp_m);
    check("out_err", out_err, (exp_m != 0));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_xs3", out_xs3, exp_x);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1 check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] w;
    // reset held for three cycles
    rstn = 1'b0;
    en = 1'b1;
    repeat (3) tick();
    check("rst_in_ready_low", in_ready, 0);
    rstn = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_xs3", out_xs3, 0);
    check("rst_err_mask", out_err_mask, 0);
    check("rst_out_err", out_err, 0);

    run_word(16'h1234, 0, 0, 0);
    check("dir_1234", out_xs3, 16'h4567);
    run_word(16'h0A9F, 0, 0, 0);
    check("dir_0a9f", out_xs3, 16'h30C0);
    check("dir_0a9f_mask", out_err_mask, 4'b0101);
    run_word(16'h9870, 1, 3, 0);
    check("dir_9870", out_xs3, 16'hCBA3);
    run_word(16'h4321, 0, 0, 5);
    run_word(16'h0099, 0, 0, 0);
    check("dir_0099", out_xs3, 16'h33CC);

    // reset mid-conversion discards the word
    en = 1'b1;
    in_bcd = 16'h5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rstn = 1'b0;
    #1 check("midrst_in_ready", in_ready, 0);
    tick();
    rstn = 1'b1;
    #1 check("midrst_valid", out_valid, 0);
    check("midrst_xs3", out_xs3, 0);
    check("midrst_mask", out_err_mask, 0);
    check("midrst_in_ready_after", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_valid", out_valid, 0);
    end
    run_word(16'h0001, 0, 0, 0);
    check("dir_0001", out_xs3, 16'h3334);

    for (int i = 0; i < 25; i++) begin
      w = W'($urandom);
      run_word(w, $urandom_range(0, DIGITS - 1), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
